// File: rtl/r22sdf_bitrev_reorder.sv
// Ping-pong reorder buffer: takes bit-reversed SDF frames and re-emits them in natural order.
// Optional dout_sof output is enabled by defining R22SDF_REORDER_SOF_EN.
//
// state | meaning
// IDLE  | no complete frame to drain; dout_vld low, data held
// READ  | draining bank rd_bank in natural order, one word per enabled edge
module r22sdf_bitrev_reorder #(
  parameter int data_resolution = 16,
  parameter int fft_pts = 4,
  localparam int aw = $clog2(fft_pts)
) (
  input  logic                       sys_clk,
  input  logic                       sys_nrst,
  input  logic                       sys_en,
  input  logic                       din_vld,
  input  logic [data_resolution-1:0] din_r,
  input  logic [data_resolution-1:0] din_i,
  output logic                       dout_vld,
  output logic [data_resolution-1:0] dout_r,
  output logic [data_resolution-1:0] dout_i,
  output logic [aw-1:0]              dout_idx
`ifdef R22SDF_REORDER_SOF_EN
  ,
  output logic                       dout_sof
`endif
);

  localparam int dw = 2 * data_resolution;
  localparam logic [aw-1:0] last_idx = aw'(fft_pts - 1);

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [dw-1:0] mem [0:2*fft_pts-1];
  logic [dw-1:0] rd_word;
  logic [aw-1:0] wr_cnt;
  logic [aw-1:0] rd_cnt;
  logic          wr_bank;
  logic          rd_bank;
  logic [1:0]    full;
  logic [1:0]    full_nxt;
  logic          wr_last;
  logic          rd_act;
  logic          rd_last;

  function automatic logic [aw-1:0] bitrev(input logic [aw-1:0] a);
    logic [aw-1:0] r;
    for (int b = 0; b < aw; b++) r[b] = a[aw-1-b];
    return r;
  endfunction

  // A frame becoming full is drained starting on the very next edge, so the word for
  // index 0 is fetched on the IDLE->READ edge itself (one-cycle latency after the last write).
  always_comb begin
    wr_last  = din_vld && (wr_cnt == last_idx);
    rd_act   = (state == READ) || full[rd_bank];
    rd_last  = rd_act && (rd_cnt == last_idx);
    rd_word  = mem[{rd_bank, rd_cnt}];
    full_nxt = full;
    if (wr_last) full_nxt[wr_bank] = 1'b1;
    if (rd_last) full_nxt[rd_bank] = 1'b0;
    state_nxt = state;
    case (state)
      IDLE: if (full[rd_bank]) state_nxt = READ;
      READ: begin
        if (rd_last) begin
          if (full[~rd_bank] || (wr_last && (wr_bank != rd_bank))) state_nxt = READ;
          else state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_nrst) state <= IDLE;
    else if (sys_en) state <= state_nxt;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_nrst && sys_en && din_vld) mem[{wr_bank, bitrev(wr_cnt)}] <= {din_r, din_i};
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_nrst) begin
      wr_cnt   <= '0;
      wr_bank  <= 1'b0;
      rd_cnt   <= '0;
      rd_bank  <= 1'b0;
      full     <= 2'b00;
      dout_vld <= 1'b0;
      dout_r   <= '0;
      dout_i   <= '0;
      dout_idx <= '0;
`ifdef R22SDF_REORDER_SOF_EN
      dout_sof <= 1'b0;
`endif
    end else if (sys_en) begin
      full <= full_nxt;
      if (din_vld) begin
        wr_cnt <= wr_cnt + 1'b1;
        if (wr_last) wr_bank <= ~wr_bank;
      end
      if (rd_act) begin
        dout_r   <= rd_word[dw-1:data_resolution];
        dout_i   <= rd_word[data_resolution-1:0];
        dout_idx <= rd_cnt;
        dout_vld <= 1'b1;
        rd_cnt   <= rd_cnt + 1'b1;
        if (rd_last) rd_bank <= ~rd_bank;
`ifdef R22SDF_REORDER_SOF_EN
        dout_sof <= (rd_cnt == '0);
`endif
      end else begin
        dout_vld <= 1'b0;
`ifdef R22SDF_REORDER_SOF_EN
        dout_sof <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_r22sdf_bitrev_reorder.sv
// Directed bench for r22sdf_bitrev_reorder: an N=4 and an N=16 instance share one clock.
// Define R22SDF_REORDER_SOF_EN to also check dout_sof.
module tb_r22sdf_bitrev_reorder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // N=4 instance
  logic        nrst4, en4, vld4, ovld4, osof4;
  logic [15:0] r4, i4, or4, oi4;
  logic [1:0]  oidx4;
  // N=16 instance
  logic        nrst16, en16, vld16, ovld16, osof16;
  logic [15:0] r16, i16, or16, oi16;
  logic [3:0]  oidx16;

  r22sdf_bitrev_reorder #(.data_resolution(16), .fft_pts(4)) u4 (
    .sys_clk(clk), .sys_nrst(nrst4), .sys_en(en4), .din_vld(vld4),
    .din_r(r4), .din_i(i4), .dout_vld(ovld4), .dout_r(or4), .dout_i(oi4),
    .dout_idx(oidx4)
`ifdef R22SDF_REORDER_SOF_EN
    , .dout_sof(osof4)
`endif
  );

  r22sdf_bitrev_reorder #(.data_resolution(16), .fft_pts(16)) u16 (
    .sys_clk(clk), .sys_nrst(nrst16), .sys_en(en16), .din_vld(vld16),
    .din_r(r16), .din_i(i16), .dout_vld(ovld16), .dout_r(or16), .dout_i(oi16),
    .dout_idx(oidx16)
`ifdef R22SDF_REORDER_SOF_EN
    , .dout_sof(osof16)
`endif
  );

`ifndef R22SDF_REORDER_SOF_EN
  assign osof4  = 1'b0;
  assign osof16 = 1'b0;
`endif

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int br4[4]   = '{0, 2, 1, 3};
  int br16[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

  // A write into a bank that is still full would overwrite an undrained frame.
  always @(negedge clk) begin
    if (nrst16 && en16 && vld16) chk("overrun16", {31'd0, u16.full[u16.wr_bank]}, 32'd0);
  end

  task automatic feed4(input int base);
    for (int k = 0; k < 4; k++) begin
      vld4 = 1'b1;
      r4 = 16'(base + br4[k]);
      i4 = 16'(base + 10 + br4[k]);
      tick();
    end
    vld4 = 1'b0;
  endtask

  task automatic expect4(input string tag, input int base, input int k0, input int cnt);
    for (int k = k0; k < k0 + cnt; k++) begin
      tick();
      chk({tag, "_vld"}, {31'd0, ovld4}, 32'd1);
      chk({tag, "_r"}, {16'd0, or4}, 32'(base + k));
      chk({tag, "_i"}, {16'd0, oi4}, 32'(base + 10 + k));
      chk({tag, "_idx"}, {30'd0, oidx4}, 32'(k));
    end
  endtask

  int last_edge[2];

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    nrst4 = 1'b0; en4 = 1'b1; vld4 = 1'b0; r4 = '0; i4 = '0;
    nrst16 = 1'b0; en16 = 1'b1; vld16 = 1'b0; r16 = '0; i16 = '0;
    tick(); tick();
    nrst4 = 1'b1; nrst16 = 1'b1;
    chk("rst_vld4", {31'd0, ovld4}, 32'd0);
    chk("rst_r4", {16'd0, or4}, 32'd0);
    chk("rst_idx4", {30'd0, oidx4}, 32'd0);
    chk("rst_vld16", {31'd0, ovld16}, 32'd0);
`ifdef R22SDF_REORDER_SOF_EN
    chk("rst_sof16", {31'd0, osof16}, 32'd0);
`endif

    // Test 1: single N=4 frame, r 0,2,1,3 / i 10,12,11,13
    feed4(0);
    chk("t1_pre_vld", {31'd0, ovld4}, 32'd0);
    expect4("t1", 0, 0, 4);
    tick();
    chk("t1_post_vld", {31'd0, ovld4}, 32'd0);
    chk("t1_hold_r", {16'd0, or4}, 32'd3);

    // Test 4: freeze with sys_en low after idx 1
    feed4(20);
    expect4("t4a", 20, 0, 2);
    en4 = 1'b0;
    for (int s = 0; s < 5; s++) begin
      tick();
      chk("t4_hold_vld", {31'd0, ovld4}, 32'd1);
      chk("t4_hold_idx", {30'd0, oidx4}, 32'd1);
      chk("t4_hold_r", {16'd0, or4}, 32'd21);
    end
    en4 = 1'b1;
    expect4("t4b", 20, 2, 2);
    tick();
    chk("t4_post_vld", {31'd0, ovld4}, 32'd0);

    // Test 5: reset after two samples of a partial frame
    vld4 = 1'b1; r4 = 16'd50; i4 = 16'd60; tick();
    r4 = 16'd52; i4 = 16'd62; tick();
    vld4 = 1'b0; nrst4 = 1'b0; tick();
    nrst4 = 1'b1;
    chk("t5_rst_vld", {31'd0, ovld4}, 32'd0);
    chk("t5_rst_r", {16'd0, or4}, 32'd0);
    chk("t5_rst_i", {16'd0, oi4}, 32'd0);
    chk("t5_rst_idx", {30'd0, oidx4}, 32'd0);
    feed4(60);
    chk("t5_pre_vld", {31'd0, ovld4}, 32'd0);
    expect4("t5", 60, 0, 4);
    tick();
    chk("t5_post_vld", {31'd0, ovld4}, 32'd0);

    // Test 2 (and 6): three back-to-back N=16 frames, value 16*f+k
    fork
      begin
        for (int f = 0; f < 3; f++) begin
          for (int k = 0; k < 16; k++) begin
            vld16 = 1'b1;
            r16 = 16'(16 * f + br16[k]);
            i16 = 16'(256 + 16 * f + br16[k]);
            tick();
          end
        end
        vld16 = 1'b0;
      end
      begin
        int c;
        c = 0;
        do begin
          tick();
          c++;
        end while (!ovld16 && c < 40);
        chk("t2_lat", 32'(c), 32'd17);
        for (int n = 0; n < 48; n++) begin
          if (n > 0) tick();
          chk("t2_vld", {31'd0, ovld16}, 32'd1);
          chk("t2_r", {16'd0, or16}, 32'(n));
          chk("t2_i", {16'd0, oi16}, 32'(256 + n));
          chk("t2_idx", {28'd0, oidx16}, 32'(n % 16));
`ifdef R22SDF_REORDER_SOF_EN
          chk("t6_sof", {31'd0, osof16}, (n % 16 == 0) ? 32'd1 : 32'd0);
`endif
        end
        tick();
        chk("t2_post_vld", {31'd0, ovld16}, 32'd0);
      end
    join

    // Test 3: N=16 with random input gaps, values 48..79
    last_edge[0] = 0;
    last_edge[1] = 0;
    fork
      begin
        int k;
        k = 0;
        while (k < 32) begin
          vld16 = 1'($urandom_range(0, 1));
          r16 = 16'(48 + 16 * (k / 16) + br16[k % 16]);
          i16 = 16'(512 + 48 + 16 * (k / 16) + br16[k % 16]);
          tick();
          if (vld16) begin
            if (k % 16 == 15) last_edge[k / 16] = cyc;
            k++;
          end
        end
        vld16 = 1'b0;
      end
      begin
        int seen, prev;
        seen = 0;
        prev = 0;
        for (int t = 0; t < 400 && seen < 32; t++) begin
          tick();
          if (ovld16) begin
            chk("t3_r", {16'd0, or16}, 32'(48 + seen));
            chk("t3_i", {16'd0, oi16}, 32'(560 + seen));
            chk("t3_idx", {28'd0, oidx16}, 32'(seen % 16));
            if (seen % 16 == 0) chk("t3_lat", 32'(cyc), 32'(last_edge[seen / 16] + 1));
            else chk("t3_gap", 32'(cyc), 32'(prev + 1));
            prev = cyc;
            seen++;
          end
        end
        chk("t3_count", 32'(seen), 32'd32);
      end
    join
    tick();
    chk("t3_post_vld", {31'd0, ovld16}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
